game_level_config: RTL and testbench
====================================

# game_level_config

Parametrised difficulty-level configurator for the Saper (minesweeper) game. It latches a level request and looks up that level's grid dimension, tile size and mine count from parameter tables. It derives the board pixel size, a centred board position and a clamped mine count through a short arithmetic pipeline. It publishes the configuration to game logic with a valid/ack handshake, holds it for the whole game, and allows re-selection via restart.

## Interface

- NUM_LEVELS, 3, number of selectable levels (1..NUM_LEVELS); must be ≥ 1
- LVL_W, $clog2(NUM_LEVELS+1), width of level input
- LVL_BUTTONS, {5'd16,5'd10,5'd8}, packed NUM_LEVELS×5 grid dimension per level, level 1 in LSB slice
- LVL_BSIZE, {7'd40,7'd50,7'd50}, packed NUM_LEVELS×7 tile size in pixels
- LVL_MINES, {10'd50,10'd20,10'd8}, packed NUM_LEVELS×10 requested mine count
- CENTER_X, 720, board centre x (pixels)
- CENTER_Y, 450, board centre y (pixels)

Ports:

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- level  in  LVL_W  requested level, 0 = none
- restart  in  1  abort or finish game, return to selection
- cfg_ack  in  1  game logic accepts configuration
- cfg_valid  out  1  configuration published, awaiting ack
- locked  out  1  configuration accepted and held
- busy  out  1  selection in progress
- level_err  out  1  one-cycle pulse: out-of-range level
- mines_out  out  10  effective mine count
- button_num  out  5  grid dimension (tiles per side)
- button_size  out  7  tile size, pixels
- board_size  out  12  button_num × button_size
- board_xpos  out  11  board left edge
- board_ypos  out  11  board top edge

## Operation

- FSM states: IDLE, LOAD, CALC, POS, PUBLISH, LOCKED.
- IDLE:
  - level in 1..NUM_LEVELS: latch level, go to LOAD.
  - level > NUM_LEVELS: pulse level_err for one cycle, stay in IDLE.
  - level == 0: stay in IDLE.
- LOAD: register the table entries for the latched level. Go to CALC.
- CALC:
  - board_size = button_num × button_size (12 bits, no overflow for 5×7 operands).
  - cells = button_num² (10 bits).
  - Go to POS.
- POS:
  - half = board_size >> 1.
  - board_xpos = CENTER_X − half, or 0 if half > CENTER_X. board_ypos is computed the same way against CENTER_Y.
  - mines_out = min(LVL_MINES, cells − 1). If cells == 0, mines_out = 0.
  - Go to PUBLISH.
- PUBLISH: cfg_valid = 1. Config outputs are stable. On cfg_ack, go to LOCKED.
- LOCKED: locked = 1. Config outputs are held unchanged. level is ignored.
- restart in any non-IDLE state: go to IDLE. All config outputs are zeroed.
- restart and cfg_ack in the same cycle: restart wins.
- cfg_ack outside PUBLISH is ignored.
- busy = 1 in LOAD, CALC, POS and PUBLISH.
- Changes on level after latching are ignored until the FSM returns to IDLE.

## Timing

- All outputs are registered.
- Reset values: every output is 0; state is IDLE.
- rst has priority over all inputs. rst during any state returns the block to IDLE on the next edge.
- Latency:
  - Valid level sampled at edge N: busy goes to 1 after edge N+1.
  - cfg_valid goes to 1 after edge N+4.
  - Config outputs are valid from the same cycle cfg_valid rises.
- Handshake:
  - cfg_valid is held until cfg_ack is sampled high.
  - On ack, after the next edge: cfg_valid = 0, locked = 1, busy = 0.
- Restart: one edge later, state is IDLE and all outputs are 0. A new level can be sampled in the following cycle.
- level_err is high for exactly the cycle after the edge that sampled the invalid level.

## Test plan

- Reset, then level=1 for one cycle, then cfg_ack when cfg_valid rises:
  - Required: cfg_valid 4 cycles after sampling.
  - Values: button_num=8, button_size=50, board_size=400, xpos=520, ypos=250, mines=8.
  - Then locked=1 and outputs held.
- level=3:
  - Required: board_size=640, xpos=400, ypos=130, mines=50, button_num=16.
  - With cfg_ack withheld 20 cycles, cfg_valid stays high and outputs stay stable.
- Override parameters to level 1 = 2 tiles × 10 px, 10 mines:
  - Required: mines_out=3 (clamped to cells−1).
- Tile 127 px with 31 tiles (board_size=3937):
  - Required: xpos=0, ypos=0 (clamped).
- level=4 with NUM_LEVELS=3:
  - Required: level_err pulses for 1 cycle, state stays IDLE, cfg_valid never rises.
- Abort cases:
  - restart and cfg_ack together in PUBLISH: required IDLE with outputs 0, locked stays 0.
  - rst asserted in CALC: required all outputs 0 next cycle.
  - level=2 then restart while LOCKED: required reselection, board_size=500, xpos=470, ypos=200, mines=20.

Source files
------------

// File: rtl/game_level_config_if.sv
// Configuration bus between the level selector/game logic and game_level_config.
// master drives level requests and the handshake; slave publishes the board setup.
interface game_level_config_if #(
  parameter int LVL_W = 2
);
  logic [LVL_W-1:0] level;
  logic             restart;
  logic             cfg_ack;
  logic             cfg_valid;
  logic             locked;
  logic             busy;
  logic             level_err;
  logic [9:0]       mines_out;
  logic [4:0]       button_num;
  logic [6:0]       button_size;
  logic [11:0]      board_size;
  logic [10:0]      board_xpos;
  logic [10:0]      board_ypos;

  modport master (
    output level, restart, cfg_ack,
    input  cfg_valid, locked, busy, level_err, mines_out,
           button_num, button_size, board_size, board_xpos, board_ypos
  );

  modport slave (
    input  level, restart, cfg_ack,
    output cfg_valid, locked, busy, level_err, mines_out,
           button_num, button_size, board_size, board_xpos, board_ypos
  );
endinterface

// File: rtl/game_level_config.sv
// Saper difficulty configurator: latches a level, looks up its board tables, derives
// size/centred position/clamped mines, and publishes them with a valid/ack handshake.
module game_level_config #(
  parameter int                      NUM_LEVELS  = 3,
  parameter int                      LVL_W       = $clog2(NUM_LEVELS + 1),
  parameter logic [NUM_LEVELS*5-1:0]  LVL_BUTTONS = {5'd16, 5'd10, 5'd8},
  parameter logic [NUM_LEVELS*7-1:0]  LVL_BSIZE   = {7'd40, 7'd50, 7'd50},
  parameter logic [NUM_LEVELS*10-1:0] LVL_MINES   = {10'd50, 10'd20, 10'd8},
  parameter int                      CENTER_X    = 720,
  parameter int                      CENTER_Y    = 450
) (
  input logic               clk,
  input logic               rst,
  game_level_config_if.slave cfg
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, POS, PUBLISH, LOCKED} state_t;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS);
  localparam logic [10:0]      CX      = 11'(CENTER_X);
  localparam logic [10:0]      CY      = 11'(CENTER_Y);

  state_t state, next_state;
  logic   level_ok, abort, ack_accept, busy_state;

  logic [LVL_W-1:0] level_q;
  logic [4:0]       button_num_q;
  logic [6:0]       button_size_q;
  logic [9:0]       mines_req_q, cells_q, mines_q;
  logic [11:0]      board_size_q;
  logic [10:0]      xpos_q, ypos_q;
  logic             cfg_valid_q, locked_q, busy_q, level_err_q;

  logic [4:0]  tbl_buttons;
  logic [6:0]  tbl_bsize;
  logic [9:0]  tbl_mines;
  logic [10:0] half, xpos_d, ypos_d;
  logic [9:0]  cells_m1, mines_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    ack_accept = 1'b0;
    level_ok   = (cfg.level != '0) && (cfg.level <= MAX_LVL);
    abort      = cfg.restart && (state != IDLE);
    busy_state = state inside {LOAD, CALC, POS, PUBLISH};
    case (state)
      IDLE:    if (level_ok) next_state = LOAD;
      LOAD:    next_state = CALC;
      CALC:    next_state = POS;
      POS:     next_state = PUBLISH;
      // Ack only counts once the published outputs are actually visible.
      PUBLISH: if (cfg.cfg_ack && cfg_valid_q && !abort) begin
        next_state = LOCKED;
        ack_accept = 1'b1;
      end
      LOCKED:  next_state = LOCKED;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_comb begin
    tbl_buttons = '0;
    tbl_bsize   = '0;
    tbl_mines   = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (level_q == LVL_W'(i + 1)) begin
        tbl_buttons = LVL_BUTTONS[i*5 +: 5];
        tbl_bsize   = LVL_BSIZE[i*7 +: 7];
        tbl_mines   = LVL_MINES[i*10 +: 10];
      end
    end
    half     = board_size_q[11:1];
    xpos_d   = (half > CX) ? '0 : CX - half;
    ypos_d   = (half > CY) ? '0 : CY - half;
    cells_m1 = cells_q - 10'd1;
    // At least one tile must stay mine-free; an empty board gets no mines.
    if (cells_q == '0)             mines_d = '0;
    else if (mines_req_q < cells_m1) mines_d = mines_req_q;
    else                           mines_d = cells_m1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q       <= '0;
      button_num_q  <= '0;
      button_size_q <= '0;
      mines_req_q   <= '0;
      cells_q       <= '0;
      board_size_q  <= '0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      mines_q       <= '0;
      cfg_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      busy_q        <= 1'b0;
      level_err_q   <= 1'b0;
    end else begin
      level_err_q <= (state == IDLE) && (cfg.level > MAX_LVL);
      busy_q      <= busy_state && !abort && !ack_accept;
      cfg_valid_q <= (state == PUBLISH) && !abort && !ack_accept;
      locked_q    <= ((state == LOCKED) && !abort) || ack_accept;
      if (abort) begin
        level_q       <= '0;
        button_num_q  <= '0;
        button_size_q <= '0;
        mines_req_q   <= '0;
        cells_q       <= '0;
        board_size_q  <= '0;
        xpos_q        <= '0;
        ypos_q        <= '0;
        mines_q       <= '0;
      end else begin
        case (state)
          IDLE: if (level_ok) level_q <= cfg.level;
          LOAD: begin
            button_num_q  <= tbl_buttons;
            button_size_q <= tbl_bsize;
            mines_req_q   <= tbl_mines;
          end
          CALC: begin
            board_size_q <= {7'd0, button_num_q} * {5'd0, button_size_q};
            cells_q      <= {5'd0, button_num_q} * {5'd0, button_num_q};
          end
          POS: begin
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            mines_q <= mines_d;
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg.cfg_valid   = cfg_valid_q;
  assign cfg.locked      = locked_q;
  assign cfg.busy        = busy_q;
  assign cfg.level_err   = level_err_q;
  assign cfg.mines_out   = mines_q;
  assign cfg.button_num  = button_num_q;
  assign cfg.button_size = button_size_q;
  assign cfg.board_size  = board_size_q;
  assign cfg.board_xpos  = xpos_q;
  assign cfg.board_ypos  = ypos_q;

endmodule

// File: tb/tb_game_level_config.sv
// Bench for game_level_config: two instances (default tables and edge-case tables) share
// one random stimulus stream and are compared against an arithmetic reference model.
module tb_game_level_config;

  typedef struct {
    int valid, locked, busy, err, mines, bn, bs, bsize, x, y;
  } obs_t;

  // Reference tables, level 1 first: [instance][level-1]
  localparam int BN [2][3] = '{'{8, 10, 16}, '{2, 31, 0}};
  localparam int BS [2][3] = '{'{50, 50, 40}, '{10, 127, 10}};
  localparam int MN [2][3] = '{'{8, 20, 50}, '{10, 100, 5}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] level = '0;
  logic       restart = 1'b0;
  logic       cfg_ack = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  game_level_config_if #(.LVL_W(3)) if_a ();
  game_level_config_if #(.LVL_W(3)) if_b ();

  assign if_a.level   = level;
  assign if_a.restart = restart;
  assign if_a.cfg_ack = cfg_ack;
  assign if_b.level   = level;
  assign if_b.restart = restart;
  assign if_b.cfg_ack = cfg_ack;

  game_level_config #(.LVL_W(3)) dut_a (.clk(clk), .rst(rst), .cfg(if_a));

  game_level_config #(
    .LVL_W      (3),
    .LVL_BUTTONS({5'd0, 5'd31, 5'd2}),
    .LVL_BSIZE  ({7'd10, 7'd127, 7'd10}),
    .LVL_MINES  ({10'd5, 10'd100, 10'd10})
  ) dut_b (.clk(clk), .rst(rst), .cfg(if_b));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.valid = int'(if_a.cfg_valid);  o.locked = int'(if_a.locked);
      o.busy  = int'(if_a.busy);       o.err    = int'(if_a.level_err);
      o.mines = int'(if_a.mines_out);  o.bn     = int'(if_a.button_num);
      o.bs    = int'(if_a.button_size); o.bsize = int'(if_a.board_size);
      o.x     = int'(if_a.board_xpos); o.y      = int'(if_a.board_ypos);
    end else begin
      o.valid = int'(if_b.cfg_valid);  o.locked = int'(if_b.locked);
      o.busy  = int'(if_b.busy);       o.err    = int'(if_b.level_err);
      o.mines = int'(if_b.mines_out);  o.bn     = int'(if_b.button_num);
      o.bs    = int'(if_b.button_size); o.bsize = int'(if_b.board_size);
      o.x     = int'(if_b.board_xpos); o.y      = int'(if_b.board_ypos);
    end
    return o;
  endfunction

  // Expected outputs straight from the board arithmetic; lvl outside 1..3 means "no config".
  function automatic obs_t model(input int sel, input int lvl, input int v, input int l,
                                 input int b, input int e);
    obs_t m;
    int   half, cells;
    m.valid = v; m.locked = l; m.busy = b; m.err = e;
    if (lvl < 1 || lvl > 3) begin
      m.bn = 0; m.bs = 0; m.bsize = 0; m.x = 0; m.y = 0; m.mines = 0;
    end else begin
      m.bn    = BN[sel][lvl-1];
      m.bs    = BS[sel][lvl-1];
      m.bsize = m.bn * m.bs;
      half    = m.bsize / 2;
      m.x     = (half > 720) ? 0 : 720 - half;
      m.y     = (half > 450) ? 0 : 450 - half;
      cells   = m.bn * m.bn;
      if (cells == 0)               m.mines = 0;
      else if (MN[sel][lvl-1] < cells - 1) m.mines = MN[sel][lvl-1];
      else                          m.mines = cells - 1;
    end
    return m;
  endfunction

  task automatic expect_all(input string tag, input int lvl, input int v, input int l,
                            input int b, input int e);
    obs_t o, m;
    for (int s = 0; s < 2; s++) begin
      o = observe(s);
      m = model(s, lvl, v, l, b, e);
      check($sformatf("%s[%0d].cfg_valid", tag, s), o.valid, m.valid);
      check($sformatf("%s[%0d].locked", tag, s), o.locked, m.locked);
      check($sformatf("%s[%0d].busy", tag, s), o.busy, m.busy);
      check($sformatf("%s[%0d].level_err", tag, s), o.err, m.err);
      check($sformatf("%s[%0d].mines_out", tag, s), o.mines, m.mines);
      check($sformatf("%s[%0d].button_num", tag, s), o.bn, m.bn);
      check($sformatf("%s[%0d].button_size", tag, s), o.bs, m.bs);
      check($sformatf("%s[%0d].board_size", tag, s), o.bsize, m.bsize);
      check($sformatf("%s[%0d].board_xpos", tag, s), o.x, m.x);
      check($sformatf("%s[%0d].board_ypos", tag, s), o.y, m.y);
    end
  endtask

  task automatic check_flags(input string tag, input int v, input int l, input int b);
    obs_t o;
    for (int s = 0; s < 2; s++) begin
      o = observe(s);
      check($sformatf("%s[%0d].cfg_valid", tag, s), o.valid, v);
      check($sformatf("%s[%0d].locked", tag, s), o.locked, l);
      check($sformatf("%s[%0d].busy", tag, s), o.busy, b);
      check($sformatf("%s[%0d].level_err", tag, s), o.err, 0);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ack then restart from LOCKED; 1: restart+ack in PUBLISH; 2: rst while in CALC
  task automatic run_sel(input int lvl, input int ack_wait, input int mode);
    level = 3'(lvl);
    tick();
    if (lvl < 1 || lvl > 3) begin
      level = '0;
      expect_all("sel_err", 0, 0, 0, 0, (lvl > 3) ? 1 : 0);
      tick();
      expect_all("err_gone", 0, 0, 0, 0, 0);
      tick();
      check_flags("stay_idle", 0, 0, 0);
      return;
    end
    // In LOAD: level changes and stray acks must be ignored from here on.
    level   = 3'($urandom_range(0, 7));
    cfg_ack = 1'($urandom_range(0, 1));
    expect_all("latched", 0, 0, 0, 0, 0);
    tick();
    check_flags("busy_load", 0, 0, 1);
    if (mode == 2) begin
      rst = 1'b1;
      tick();
      rst = 1'b0; level = '0; cfg_ack = 1'b0;
      expect_all("rst_calc", 0, 0, 0, 0, 0);
      return;
    end
    level   = 3'($urandom_range(0, 7));
    cfg_ack = 1'($urandom_range(0, 1));
    tick();
    cfg_ack = 1'b0;
    check_flags("busy_calc", 0, 0, 1);
    tick();
    check_flags("busy_pos", 0, 0, 1);
    tick();
    expect_all("published", lvl, 1, 0, 1, 0);
    if (mode == 1) begin
      restart = 1'b1; cfg_ack = 1'b1;
      tick();
      restart = 1'b0; cfg_ack = 1'b0; level = '0;
      expect_all("restart_ack", 0, 0, 0, 0, 0);
      return;
    end
    for (int i = 0; i < ack_wait; i++) begin
      level = 3'($urandom_range(0, 7));
      tick();
      expect_all("hold_valid", lvl, 1, 0, 1, 0);
    end
    cfg_ack = 1'b1;
    tick();
    cfg_ack = 1'b0;
    expect_all("acked", lvl, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      level   = 3'($urandom_range(0, 7));
      cfg_ack = 1'($urandom_range(0, 1));
      tick();
      expect_all("locked_hold", lvl, 0, 1, 0, 0);
    end
    restart = 1'b1; cfg_ack = 1'b0;
    tick();
    restart = 1'b0; level = '0;
    expect_all("restarted", 0, 0, 0, 0, 0);
  endtask

  initial begin
    tick();
    tick();
    expect_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    expect_all("idle", 0, 0, 0, 0, 0);

    run_sel(1, 0, 0);
    run_sel(3, 20, 0);
    run_sel(4, 0, 0);
    run_sel(1, 0, 1);
    run_sel(2, 0, 2);
    run_sel(2, 1, 0);
    run_sel(2, 0, 0);
    run_sel(0, 0, 0);

    for (int t = 0; t < 40; t++)
      run_sel(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
